// File: rtl/mux_n_pipe_if.sv
// Upstream/downstream handshake bundle for mux_n_pipe.
// Signal suffixes are from the block's point of view. The slave modport belongs to the block.
interface mux_n_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) ();
  localparam int SEL_W = $clog2(NUM_IN);

  logic                    flush_i;
  logic [NUM_IN*WIDTH-1:0] data_i;
  logic [SEL_W-1:0]        select_i;
  logic                    valid_i;
  logic                    ready_o;
  logic [WIDTH-1:0]        data_o;
  logic                    valid_o;
  logic                    ready_i;
  logic                    sel_err_o;
  logic                    err_clr_i;

  modport slave (
    input  flush_i, data_i, select_i, valid_i, ready_i, err_clr_i,
    output ready_o, data_o, valid_o, sel_err_o
  );

  modport master (
    output flush_i, data_i, select_i, valid_i, ready_i, err_clr_i,
    input  ready_o, data_o, valid_o, sel_err_o
  );
endinterface

// File: rtl/mux_n_pipe.sv
// N:1 channel select into a registered output stage with a 2-entry skid buffer.
// Includes flush, and a sticky flag for out-of-range selects.
module mux_n_pipe #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 4,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input logic          clk_i,
  input logic          rst_i,
  mux_n_pipe_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_IN);
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] sel_val;
  logic             sel_oor, acc, pop;

  // Out-of-range selects fall through to DEFAULT_VAL.
  always_comb begin
    sel_val = DEFAULT_VAL;
    for (int k = 0; k < NUM_IN; k++)
      if (bus.select_i == SEL_W'(k)) sel_val = bus.data_i[k*WIDTH +: WIDTH];
  end

  assign sel_oor = {1'b0, bus.select_i} >= NUM_IN_W;
  assign acc     = bus.valid_i & bus.ready_o;
  assign pop     = bus.valid_o & bus.ready_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    err_d   = err_q;
    if (bus.flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (acc) begin state_d = ONE; data_d = sel_val; end
        ONE: begin
          if (acc && !pop)     begin state_d = FULL; skid_d = sel_val; end
          else if (acc && pop) data_d = sel_val;
          else if (pop)        state_d = EMPTY;
        end
        FULL: if (pop) begin state_d = ONE; data_d = skid_q; end
        default: state_d = EMPTY;
      endcase
    end
    // Set beats clear when both happen in the same cycle.
    if (bus.err_clr_i) err_d = 1'b0;
    if (acc && sel_oor && !bus.flush_i) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      skid_q  <= skid_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs decode registered state only, so nothing feeds through combinationally.
  assign bus.ready_o   = (state_q != FULL);
  assign bus.valid_o   = (state_q != EMPTY);
  assign bus.data_o    = data_q;
  assign bus.sel_err_o = err_q;
endmodule
